// File: rtl/ifu_fetch_pkg.sv
// ifu_fetch_pkg
//   Shared definitions for the instruction fetch unit: fetch FSM state
//   encoding, default reset PC, address width and instruction width.
package ifu_fetch_pkg;

    localparam int          DEF_XLEN     = 64;
    localparam logic [63:0] DEF_RESET_PC = 64'h0000_0000_8000_0000;
    localparam int          INST_W       = 32;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_REQ_ENC  = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC = 2'd2;
    localparam logic [1:0] ST_HOLD_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_REQ  = ST_REQ_ENC,
        ST_WAIT = ST_WAIT_ENC,
        ST_HOLD = ST_HOLD_ENC
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if
//   Instruction memory request/response bus used by the fetch unit.
//   master : fetch side (drives the request, receives the response)
//   slave  : memory side
//   Signals: imem_req_valid / imem_req_ready / imem_req_addr (request),
//            imem_resp_valid / imem_resp_data (single-beat response).
interface ifu_fetch_if #(
    parameter int XLEN = 64
);
    import ifu_fetch_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );

endinterface

// File: rtl/ifu_fetch.sv
// ifu_fetch
//   Instruction fetch unit feeding a stallable 3-stage pipeline. Issues one
//   instruction read at a time, holds the fetched word until the ID register
//   accepts it, and restarts at a new PC on redirect, dropping any stale
//   response that is still in flight.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   redirect_valid    one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc       redirect target (4-byte aligned)
//   imem              instruction memory bus (master side)
//   validin           instruction valid to the pipeline
//   inst, cpupc       instruction word and its PC
//   dnpc              predicted next PC (cpupc + 4)
//   not_jump          static not-taken flag, high while validin
//   id_reg_finish     pipeline accepts inst this cycle
//   fetch_count       number of instructions accepted by the pipeline
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int              XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    ifu_fetch_if.master        imem,
    output logic               validin,
    output logic [INST_W-1:0]  inst,
    output logic [XLEN-1:0]    cpupc,
    output logic [XLEN-1:0]    dnpc,
    output logic               not_jump,
    input  logic               id_reg_finish,
    output logic [XLEN-1:0]    fetch_count
);

    fetch_state_e      state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              discard_q, discard_d;
    logic              req_valid_q, req_valid_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic              validin_q, validin_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [XLEN-1:0]   cpupc_q, cpupc_d;
    logic [XLEN-1:0]   dnpc_q, dnpc_d;
    logic              not_jump_q, not_jump_d;
    logic [XLEN-1:0]   fetch_count_q, fetch_count_d;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        discard_d     = discard_q;
        req_valid_d   = req_valid_q;
        req_addr_d    = req_addr_q;
        validin_d     = validin_q;
        inst_d        = inst_q;
        cpupc_d       = cpupc_q;
        dnpc_d        = dnpc_q;
        fetch_count_d = fetch_count_q;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (redirect_valid) pc_d = redirect_pc;
            end

            ST_REQ: begin
                // The pending request is frozen on the bus even on redirect,
                // so whatever it returns is stale and must be dropped.
                if (redirect_valid) begin
                    pc_d      = redirect_pc;
                    discard_d = 1'b1;
                end
                if (imem.imem_req_ready) begin
                    state_d     = ST_WAIT;
                    req_valid_d = 1'b0;
                end
            end

            ST_WAIT: begin
                if (redirect_valid) pc_d = redirect_pc;
                if (imem.imem_resp_valid) begin
                    if (discard_q || redirect_valid) begin
                        // Outstanding request is now complete; refetch.
                        discard_d = 1'b0;
                        state_d   = ST_REQ;
                    end else begin
                        inst_d    = imem.imem_resp_data;
                        cpupc_d   = pc_q;
                        dnpc_d    = pc_q + XLEN'(4);
                        validin_d = 1'b1;
                        state_d   = ST_HOLD;
                    end
                end else if (redirect_valid) begin
                    discard_d = 1'b1;
                end
            end

            ST_HOLD: begin
                // A finish in the same cycle as a redirect still delivers
                // the held instruction; only the next PC changes.
                if (id_reg_finish) fetch_count_d = fetch_count_q + XLEN'(1);
                if (redirect_valid || id_reg_finish) begin
                    validin_d = 1'b0;
                    state_d   = ST_REQ;
                    pc_d      = redirect_valid ? redirect_pc : (pc_q + XLEN'(4));
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // Launch a fresh request on every entry into REQ; while already in
        // REQ the address stays put until accepted.
        if (state_d == ST_REQ && state_q != ST_REQ) begin
            req_valid_d = 1'b1;
            req_addr_d  = pc_d;
        end

        not_jump_d = validin_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            discard_q     <= 1'b0;
            req_valid_q   <= 1'b0;
            req_addr_q    <= RESET_PC;
            validin_q     <= 1'b0;
            inst_q        <= '0;
            cpupc_q       <= '0;
            dnpc_q        <= '0;
            not_jump_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            discard_q     <= discard_d;
            req_valid_q   <= req_valid_d;
            req_addr_q    <= req_addr_d;
            validin_q     <= validin_d;
            inst_q        <= inst_d;
            cpupc_q       <= cpupc_d;
            dnpc_q        <= dnpc_d;
            not_jump_q    <= not_jump_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem.imem_req_valid = req_valid_q;
    assign imem.imem_req_addr  = req_addr_q;
    assign validin             = validin_q;
    assign inst                = inst_q;
    assign cpupc               = cpupc_q;
    assign dnpc                = dnpc_q;
    assign not_jump            = not_jump_q;
    assign fetch_count         = fetch_count_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch
//   Directed, table-driven bench for ifu_fetch. Each vector row gives the
//   inputs for one cycle and the outputs expected during that cycle (all
//   outputs are registered, so they reflect the state before the edge that
//   consumes the inputs).
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam int          XLEN = 64;
    localparam logic [63:0] RPC  = 64'h0000_0000_8000_0000;

    logic              clk;
    logic              rst_n;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              validin;
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   cpupc;
    logic [XLEN-1:0]   dnpc;
    logic              not_jump;
    logic              id_reg_finish;
    logic [XLEN-1:0]   fetch_count;

    ifu_fetch_if #(.XLEN(XLEN)) imem ();

    ifu_fetch #(.XLEN(XLEN), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .validin        (validin),
        .inst           (inst),
        .cpupc          (cpupc),
        .dnpc           (dnpc),
        .not_jump       (not_jump),
        .id_reg_finish  (id_reg_finish),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        rsp;
        logic [31:0] dat;
        logic        redir;
        logic [63:0] rpc;
        logic        fin;
        logic        e_rv;    // expected imem_req_valid
        logic [63:0] e_ra;    // expected req addr (checked when e_rv)
        logic        e_vi;    // expected validin / not_jump
        logic [31:0] e_inst;  // checked when e_vi
        logic [63:0] e_pc;    // expected cpupc, checked when e_vi
        logic [63:0] e_fc;    // expected fetch_count
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int vidx    = 0;
    vec_t tbl[$];

    function automatic vec_t mk(input logic rdy, input logic rsp, input logic [31:0] dat,
                                input logic redir, input logic [63:0] rpc, input logic fin,
                                input logic e_rv, input logic [63:0] e_ra, input logic e_vi,
                                input logic [31:0] e_inst, input logic [63:0] e_pc,
                                input logic [63:0] e_fc);
        vec_t v;
        v.rdy = rdy; v.rsp = rsp; v.dat = dat; v.redir = redir; v.rpc = rpc; v.fin = fin;
        v.e_rv = e_rv; v.e_ra = e_ra; v.e_vi = e_vi; v.e_inst = e_inst; v.e_pc = e_pc;
        v.e_fc = e_fc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one row's inputs and compare the current outputs.
    task automatic apply_chk(input vec_t v);
        imem.imem_req_ready  = v.rdy;
        imem.imem_resp_valid = v.rsp;
        imem.imem_resp_data  = v.dat;
        redirect_valid       = v.redir;
        redirect_pc          = v.rpc;
        id_reg_finish        = v.fin;
        #1;
        chk($sformatf("v%0d req_valid", vidx), 64'(imem.imem_req_valid), 64'(v.e_rv));
        if (v.e_rv) chk($sformatf("v%0d req_addr", vidx), imem.imem_req_addr, v.e_ra);
        chk($sformatf("v%0d validin", vidx), 64'(validin), 64'(v.e_vi));
        chk($sformatf("v%0d not_jump", vidx), 64'(not_jump), 64'(v.e_vi));
        if (v.e_vi) begin
            chk($sformatf("v%0d inst", vidx), 64'(inst), 64'(v.e_inst));
            chk($sformatf("v%0d cpupc", vidx), cpupc, v.e_pc);
            chk($sformatf("v%0d dnpc", vidx), dnpc, v.e_pc + 64'd4);
        end
        chk($sformatf("v%0d fetch_count", vidx), fetch_count, v.e_fc);
        vidx++;
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        apply_chk(v);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " req_valid"}, 64'(imem.imem_req_valid), 64'd0);
        chk({tag, " req_addr"}, imem.imem_req_addr, RPC);
        chk({tag, " validin"}, 64'(validin), 64'd0);
        chk({tag, " inst"}, 64'(inst), 64'd0);
        chk({tag, " cpupc"}, cpupc, 64'd0);
        chk({tag, " dnpc"}, dnpc, 64'd0);
        chk({tag, " not_jump"}, 64'(not_jump), 64'd0);
        chk({tag, " fetch_count"}, fetch_count, 64'd0);
    endtask

    localparam logic [63:0] WRAP = 64'hFFFF_FFFF_FFFF_FFFC;

    initial begin
        rst_n                = 1'b0;
        redirect_valid       = 1'b0;
        redirect_pc          = '0;
        id_reg_finish        = 1'b0;
        imem.imem_req_ready  = 1'b0;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = '0;

        // Tests 1-4 plus HOLD redirect without finish.
        tbl.push_back(mk(0,0,32'h0,0,64'h0,0,            0,64'h0,0,32'h0,64'h0,0));        // IDLE
        tbl.push_back(mk(1,0,32'h0,0,64'h0,0,            1,RPC,0,32'h0,64'h0,0));          // REQ accept
        tbl.push_back(mk(0,1,32'h0000_0013,0,64'h0,0,    0,64'h0,0,32'h0,64'h0,0));        // WAIT resp
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,32'h0,0,64'h0,0,        0,64'h0,1,32'h13,RPC,0));         // HOLD stall
        tbl.push_back(mk(0,0,32'h0,0,64'h0,1,            0,64'h0,1,32'h13,RPC,0));         // finish
        tbl.push_back(mk(1,0,32'h0,0,64'h0,0,            1,RPC+64'd4,0,32'h0,64'h0,1));    // next req
        tbl.push_back(mk(0,0,32'h0,1,64'h8000_1000,0,    0,64'h0,0,32'h0,64'h0,1));        // WAIT redirect
        tbl.push_back(mk(0,0,32'h0,0,64'h0,0,            0,64'h0,0,32'h0,64'h0,1));
        tbl.push_back(mk(0,1,32'hDEAD_BEEF,0,64'h0,0,    0,64'h0,0,32'h0,64'h0,1));        // stale resp
        tbl.push_back(mk(1,0,32'h0,0,64'h0,0,            1,64'h8000_1000,0,32'h0,64'h0,1));
        tbl.push_back(mk(0,1,32'h0010_0093,0,64'h0,0,    0,64'h0,0,32'h0,64'h0,1));
        tbl.push_back(mk(0,0,32'h0,1,64'h8000_2000,1,    0,64'h0,1,32'h0010_0093,64'h8000_1000,1));
        tbl.push_back(mk(1,0,32'h0,0,64'h0,0,            1,64'h8000_2000,0,32'h0,64'h0,2));
        tbl.push_back(mk(0,1,32'h0000_0011,0,64'h0,0,    0,64'h0,0,32'h0,64'h0,2));
        tbl.push_back(mk(0,0,32'h0,1,64'h8000_3000,0,    0,64'h0,1,32'h11,64'h8000_2000,2)); // redirect, no finish
        tbl.push_back(mk(0,0,32'h0,0,64'h0,0,            1,64'h8000_3000,0,32'h0,64'h0,2)); // stall 1

        @(negedge clk);
        @(negedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;
        foreach (tbl[i]) begin
            if (i > 0) @(negedge clk);
            apply_chk(tbl[i]);
        end

        // Test 5: stalled request with redirect mid-stall; address must hold,
        // the response is dropped, and refetch goes to the (wrapping) target.
        step(mk(0,0,32'h0,1,WRAP,0,      1,64'h8000_3000,0,32'h0,64'h0,2));
        step(mk(0,0,32'h0,0,64'h0,0,     1,64'h8000_3000,0,32'h0,64'h0,2));
        step(mk(0,0,32'h0,0,64'h0,0,     1,64'h8000_3000,0,32'h0,64'h0,2));
        step(mk(1,0,32'h0,0,64'h0,0,     1,64'h8000_3000,0,32'h0,64'h0,2));
        step(mk(0,1,32'h0BAD_0BAD,0,64'h0,0, 0,64'h0,0,32'h0,64'h0,2));
        step(mk(1,0,32'h0,0,64'h0,0,     1,WRAP,0,32'h0,64'h0,2));
        step(mk(0,1,32'h0000_0022,0,64'h0,0, 0,64'h0,0,32'h0,64'h0,2));
        step(mk(0,0,32'h0,0,64'h0,1,     0,64'h0,1,32'h22,WRAP,2));   // dnpc wraps to 0
        step(mk(1,0,32'h0,0,64'h0,0,     1,64'h0,0,32'h0,64'h0,3));   // pc+4 wrapped

        // Test 6: asynchronous reset while in WAIT, then a late response.
        @(negedge clk);
        imem.imem_req_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        apply_chk(mk(0,1,32'h0BAD_F00D,0,64'h0,0, 0,64'h0,0,32'h0,64'h0,0)); // IDLE, ignored
        step(mk(0,1,32'h0BAD_F00D,0,64'h0,0, 1,RPC,0,32'h0,64'h0,0));        // REQ, ignored
        step(mk(1,0,32'h0,0,64'h0,0,     1,RPC,0,32'h0,64'h0,0));
        step(mk(0,1,32'h0000_0033,0,64'h0,0, 0,64'h0,0,32'h0,64'h0,0));
        step(mk(0,0,32'h0,0,64'h0,0,     0,64'h0,1,32'h33,RPC,0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
